// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
//   Shared definitions for the boot program loader: byte/word widths and the
//   4-bit loader state encoding. Imported by the loader top and its
//   byte-pair assembler.
package prog_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;

    typedef enum logic [3:0] {
        ST_HDR_HI = 4'd0,
        ST_HDR_LO = 4'd1,
        ST_DAT_HI = 4'd2,
        ST_DAT_LO = 4'd3,
        ST_WR     = 4'd4,
        ST_CHK_HI = 4'd5,
        ST_CHK_LO = 4'd6,
        ST_RUN    = 4'd7,
        ST_ERROR  = 4'd8
    } state_t;

    // States in which the next accepted byte is the high byte of a word.
    function automatic logic is_hi_state(input state_t s);
        return (s == ST_HDR_HI) || (s == ST_DAT_HI) || (s == ST_CHK_HI);
    endfunction

endpackage

// File: rtl/prog_loader_ctrl_if.sv
// prog_loader_ctrl_if
//   Bundles the loader's UART byte handshake, restart request and
//   instruction-memory / core-control outputs.
//   modport slave  : the loader (consumes rx bytes and load_req, drives the rest)
//   modport master : the surrounding system (drives rx bytes and load_req)
//   Signals:
//     rx_valid, rx_data[7:0], rx_ready      byte handshake from uart_rx
//     load_req                              restart request (RUN/ERROR only)
//     prog_ld, imem_we                      load-in-progress flag, write strobe
//     uart_read_addr[15:0], uart_read_data[15:0]  instruction write addr/data
//     cpu_pc_reset, done, error             core reset and status
//     words_loaded[15:0]                    words written in this load
interface prog_loader_ctrl_if;
    import prog_loader_pkg::*;

    logic              rx_valid;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_ready;
    logic              load_req;
    logic              prog_ld;
    logic              imem_we;
    logic [WORD_W-1:0] uart_read_addr;
    logic [WORD_W-1:0] uart_read_data;
    logic              cpu_pc_reset;
    logic              done;
    logic              error;
    logic [WORD_W-1:0] words_loaded;

    modport slave (
        input  rx_valid, rx_data, load_req,
        output rx_ready, prog_ld, imem_we, uart_read_addr, uart_read_data,
               cpu_pc_reset, done, error, words_loaded
    );

    modport master (
        output rx_valid, rx_data, load_req,
        input  rx_ready, prog_ld, imem_we, uart_read_addr, uart_read_data,
               cpu_pc_reset, done, error, words_loaded
    );

endinterface

// File: rtl/byte_pair_assembler.sv
// byte_pair_assembler
//   Latches the high byte of a big-endian byte pair and presents the full word
//   together with the low byte, so the loader can act on the word in the same
//   cycle the low byte is accepted. Shared by header, data and checksum words.
//   Ports:
//     clk            system clock
//     i_rst_n        synchronous active-low reset
//     i_byte_valid   a byte is accepted this cycle
//     i_is_hi        the accepted byte is the high byte
//     i_byte         accepted byte
//     o_word         {latched high byte, current byte}
//     o_word_valid   pulses when the low byte is accepted
module byte_pair_assembler
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_byte_valid,
    input  logic              i_is_hi,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_valid
);

    logic [BYTE_W-1:0] r_hi;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_hi <= '0;
        end else if (i_byte_valid && i_is_hi) begin
            r_hi <= i_byte;
        end
    end

    assign o_word       = {r_hi, i_byte};
    assign o_word_valid = i_byte_valid && !i_is_hi;

endmodule

// File: rtl/prog_loader_ctrl.sv
// prog_loader_ctrl
//   Boot sequencer for cpu_16bit. Holds the core in reset, receives a header
//   word count N followed by N instruction words (high byte first) from the
//   UART RX, writes each word to instruction memory and then releases the core.
//   Parameters:
//     IMEM_DEPTH   words of instruction memory; legal N is 1..IMEM_DEPTH
//     TIMEOUT_CYC  max idle clocks between accepted bytes while loading; 0 = off
//   Ports:
//     clk          system clock
//     pc_reset_n   synchronous active-low reset
//     ldr          prog_loader_ctrl_if.slave (byte handshake, load_req,
//                  imem write port, core reset, status)
//   Build option:
//     PROG_LOADER_CHECKSUM_EN  when defined, a 16-bit mod-2^16 sum of the data
//                              words follows the image and must match for RUN.
module prog_loader_ctrl
    import prog_loader_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH  = 256,
    parameter int unsigned TIMEOUT_CYC = 0
) (
    input  logic               clk,
    input  logic               pc_reset_n,
    prog_loader_ctrl_if.slave  ldr
);

    state_t            r_state;
    logic              r_rx_ready;
    logic              r_prog_ld;
    logic              r_imem_we;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_data;
    logic              r_pc_rst;
    logic              r_done;
    logic              r_error;
    logic [WORD_W-1:0] r_words;
    logic [WORD_W-1:0] r_n;
    logic [31:0]       r_to_cnt;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] r_sum;
`endif

    logic              w_accept;
    logic [WORD_W-1:0] w_word;
    logic              w_word_valid;
    logic              w_to_en;

    assign w_accept = ldr.rx_valid && r_rx_ready;

    // Idle time only counts while a byte is awaited, and not while waiting
    // for the very first header byte of a fresh load.
    assign w_to_en = r_rx_ready && !((r_state == ST_HDR_HI) && (r_words == '0));

    byte_pair_assembler u_bpa (
        .clk          (clk),
        .i_rst_n      (pc_reset_n),
        .i_byte_valid (w_accept),
        .i_is_hi      (is_hi_state(r_state)),
        .i_byte       (ldr.rx_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clk) begin
        if (!pc_reset_n) begin
            r_state    <= ST_HDR_HI;
            r_rx_ready <= 1'b1;
            r_prog_ld  <= 1'b1;
            r_imem_we  <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_pc_rst   <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_words    <= '0;
            r_n        <= '0;
            r_to_cnt   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            r_imem_we <= 1'b0;

            case (r_state)
                ST_HDR_HI: begin
                    if (w_accept) begin
                        r_state <= ST_HDR_LO;
                    end
                end

                ST_HDR_LO: begin
                    if (w_word_valid) begin
                        r_n <= w_word;
                        if ((w_word == '0) || (32'(w_word) > IMEM_DEPTH)) begin
                            r_state    <= ST_ERROR;
                            r_error    <= 1'b1;
                            r_pc_rst   <= 1'b1;
                            r_prog_ld  <= 1'b0;
                            r_rx_ready <= 1'b0;
                            r_done     <= 1'b0;
                        end else begin
                            r_state <= ST_DAT_HI;
                        end
                    end
                end

                ST_DAT_HI: begin
                    if (w_accept) begin
                        r_state <= ST_DAT_LO;
                    end
                end

                ST_DAT_LO: begin
                    if (w_word_valid) begin
                        r_data     <= w_word;
                        r_imem_we  <= 1'b1;
                        r_rx_ready <= 1'b0;
                        r_state    <= ST_WR;
                    end
                end

                ST_WR: begin
                    r_addr  <= r_addr + 16'd1;
                    r_words <= r_words + 16'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    r_sum   <= r_sum + r_data;
`endif
                    if ((r_words + 16'd1) == r_n) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_state    <= ST_CHK_HI;
                        r_rx_ready <= 1'b1;
`else
                        r_state    <= ST_RUN;
                        r_done     <= 1'b1;
                        r_prog_ld  <= 1'b0;
                        r_pc_rst   <= 1'b0;
                        r_rx_ready <= 1'b0;
`endif
                    end else begin
                        r_state    <= ST_DAT_HI;
                        r_rx_ready <= 1'b1;
                    end
                end

`ifdef PROG_LOADER_CHECKSUM_EN
                ST_CHK_HI: begin
                    if (w_accept) begin
                        r_state <= ST_CHK_LO;
                    end
                end

                ST_CHK_LO: begin
                    if (w_word_valid) begin
                        r_rx_ready <= 1'b0;
                        if (w_word == r_sum) begin
                            r_state   <= ST_RUN;
                            r_done    <= 1'b1;
                            r_prog_ld <= 1'b0;
                            r_pc_rst  <= 1'b0;
                        end else begin
                            r_state   <= ST_ERROR;
                            r_error   <= 1'b1;
                            r_pc_rst  <= 1'b1;
                            r_prog_ld <= 1'b0;
                            r_done    <= 1'b0;
                        end
                    end
                end
`endif

                ST_RUN, ST_ERROR: begin
                    if (ldr.load_req) begin
                        r_state    <= ST_HDR_HI;
                        r_rx_ready <= 1'b1;
                        r_prog_ld  <= 1'b1;
                        r_pc_rst   <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_addr     <= '0;
                        r_words    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_sum      <= '0;
`endif
                    end
                end

                default: begin
                    r_state    <= ST_ERROR;
                    r_error    <= 1'b1;
                    r_pc_rst   <= 1'b1;
                    r_prog_ld  <= 1'b0;
                    r_rx_ready <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase

            // The timeout only fires on a cycle with no accepted byte, so it
            // never collides with a byte-driven transition above; its
            // assignments are placed last so they take priority regardless.
            if ((TIMEOUT_CYC != 0) && w_to_en) begin
                if (w_accept) begin
                    r_to_cnt <= '0;
                end else if (r_to_cnt == (TIMEOUT_CYC - 32'd1)) begin
                    r_to_cnt   <= '0;
                    r_state    <= ST_ERROR;
                    r_error    <= 1'b1;
                    r_pc_rst   <= 1'b1;
                    r_prog_ld  <= 1'b0;
                    r_rx_ready <= 1'b0;
                    r_done     <= 1'b0;
                end else begin
                    r_to_cnt <= r_to_cnt + 32'd1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign ldr.rx_ready       = r_rx_ready;
    assign ldr.prog_ld        = r_prog_ld;
    assign ldr.imem_we        = r_imem_we;
    assign ldr.uart_read_addr = r_addr;
    assign ldr.uart_read_data = r_data;
    assign ldr.cpu_pc_reset   = r_pc_rst;
    assign ldr.done           = r_done;
    assign ldr.error          = r_error;
    assign ldr.words_loaded   = r_words;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// tb_prog_loader_ctrl
//   Scoreboard bench for prog_loader_ctrl (IMEM_DEPTH=256, TIMEOUT_CYC=100).
//   Expected {addr,data} pairs are queued as words are sent and popped when
//   the loader strobes imem_we. Honours PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic pc_reset_n;

    prog_loader_ctrl_if bus ();

    prog_loader_ctrl #(
        .IMEM_DEPTH  (256),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk        (clk),
        .pc_reset_n (pc_reset_n),
        .ldr        (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb_q[$];
    logic [15:0] img[$];
    int          stall_cnt;
    logic [15:0] exp_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write-port monitor: every strobe must match the oldest queued word.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("we_unexpected", {31'd0, bus.imem_we}, 32'd0);
            end else begin
                check_eq("we_addr_data", {bus.uart_read_addr, bus.uart_read_data}, sb_q.pop_front());
            end
        end
    end

    // Called just after a negedge; returns at the negedge following acceptance
    // with rx_valid still high so back-to-back bytes stream continuously.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            check_eq("rx_ready_wait", {31'd0, bus.rx_ready}, 32'd1);
        end
        stall_cnt += n;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w);
        sb_q.push_back({exp_addr, w});
        exp_addr++;
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_load_req();
        bus.load_req = 1'b1;
        @(negedge clk);
        bus.load_req = 1'b0;
    endtask

    task automatic do_reset();
        pc_reset_n   = 1'b0;
        bus.rx_valid = 1'b0;
        bus.load_req = 1'b0;
        repeat (3) @(negedge clk);
        pc_reset_n = 1'b1;
    endtask

    task automatic send_image(input logic bad_sum);
        int          n;
        logic [15:0] sum;
        logic [15:0] nw;
        n         = img.size();
        nw        = 16'(n);
        sum       = '0;
        stall_cnt = 0;
        exp_addr  = '0;
        send_byte(nw[15:8]);
        send_byte(nw[7:0]);
        foreach (img[i]) begin
            sum = sum + img[i];
            send_word(img[i]);
        end
        check_eq("last_wr_we", {31'd0, bus.imem_we}, 32'd1);
        check_eq("last_wr_pc_reset", {31'd0, bus.cpu_pc_reset}, 32'd1);
`ifdef PROG_LOADER_CHECKSUM_EN
        sum = sum + 16'(bad_sum);
        send_byte(sum[15:8]);
        send_byte(sum[7:0]);
        bus.rx_valid = 1'b0;
        check_eq("stall_cycles", 32'(stall_cnt), 32'(n));
`else
        bus.rx_valid = 1'b0;
        @(negedge clk);
        check_eq("stall_cycles", 32'(stall_cnt), 32'(n - 1));
        check_eq("bad_sum_unused", {31'd0, bad_sum}, 32'd0);
`endif
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_run(input int n);
        check_eq("run_done", {31'd0, bus.done}, 32'd1);
        check_eq("run_error", {31'd0, bus.error}, 32'd0);
        check_eq("run_pc_reset", {31'd0, bus.cpu_pc_reset}, 32'd0);
        check_eq("run_prog_ld", {31'd0, bus.prog_ld}, 32'd0);
        check_eq("run_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        check_eq("run_words", {16'd0, bus.words_loaded}, 32'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        bus.load_req = 1'b0;
        pc_reset_n   = 1'b0;
        stall_cnt    = 0;
        exp_addr     = '0;
        @(negedge clk);
        do_reset();

        // Reset state
        check_eq("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        check_eq("rst_prog_ld", {31'd0, bus.prog_ld}, 32'd1);
        check_eq("rst_pc_reset", {31'd0, bus.cpu_pc_reset}, 32'd1);
        check_eq("rst_imem_we", {31'd0, bus.imem_we}, 32'd0);
        check_eq("rst_done", {31'd0, bus.done}, 32'd0);
        check_eq("rst_error", {31'd0, bus.error}, 32'd0);
        check_eq("rst_words", {16'd0, bus.words_loaded}, 32'd0);
        check_eq("rst_addr_data", {bus.uart_read_addr, bus.uart_read_data}, 32'd0);

        // Three-word image, continuous rx_valid
        img = '{16'h1012, 16'h2034, 16'h3056};
        send_image(1'b0);
        check_run(3);
        check_eq("run_addr", {16'd0, bus.uart_read_addr}, 32'd3);

        // Restart from RUN
        pulse_load_req();
        check_eq("rl_prog_ld", {31'd0, bus.prog_ld}, 32'd1);
        check_eq("rl_pc_reset", {31'd0, bus.cpu_pc_reset}, 32'd1);
        check_eq("rl_done", {31'd0, bus.done}, 32'd0);
        check_eq("rl_words", {16'd0, bus.words_loaded}, 32'd0);
        check_eq("rl_addr", {16'd0, bus.uart_read_addr}, 32'd0);
        check_eq("rl_rx_ready", {31'd0, bus.rx_ready}, 32'd1);

        // Header N=0
        send_byte(8'h00);
        send_byte(8'h00);
        bus.rx_valid = 1'b0;
        check_eq("n0_error", {31'd0, bus.error}, 32'd1);
        check_eq("n0_pc_reset", {31'd0, bus.cpu_pc_reset}, 32'd1);
        check_eq("n0_prog_ld", {31'd0, bus.prog_ld}, 32'd0);
        check_eq("n0_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        repeat (5) @(negedge clk);
        check_eq("n0_sticky", {31'd0, bus.error}, 32'd1);
        check_eq("n0_done", {31'd0, bus.done}, 32'd0);

        pulse_load_req();
        check_eq("clr_error", {31'd0, bus.error}, 32'd0);
        check_eq("clr_rx_ready", {31'd0, bus.rx_ready}, 32'd1);

        // Header N=257 > IMEM_DEPTH
        send_byte(8'h01);
        send_byte(8'h01);
        bus.rx_valid = 1'b0;
        check_eq("n257_error", {31'd0, bus.error}, 32'd1);
        check_eq("n257_pc_reset", {31'd0, bus.cpu_pc_reset}, 32'd1);
        pulse_load_req();

        // Reset during word 2 of 4
        exp_addr = '0;
        send_byte(8'h00);
        send_byte(8'h04);
        send_word(16'h1111);
        send_byte(8'h22);
        do_reset();
        check_eq("mid_rst_words", {16'd0, bus.words_loaded}, 32'd0);
        check_eq("mid_rst_addr", {16'd0, bus.uart_read_addr}, 32'd0);
        check_eq("mid_rst_prog_ld", {31'd0, bus.prog_ld}, 32'd1);
        check_eq("mid_rst_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        img = '{16'hA5A5, 16'h5A01};
        send_image(1'b0);
        check_run(2);

        // Inter-byte timeout after a DAT_HI byte
        pulse_load_req();
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'hAB);
        bus.rx_valid = 1'b0;
        repeat (99) @(negedge clk);
        check_eq("to_before", {31'd0, bus.error}, 32'd0);
        @(negedge clk);
        check_eq("to_error", {31'd0, bus.error}, 32'd1);
        check_eq("to_pc_reset", {31'd0, bus.cpu_pc_reset}, 32'd1);
        pulse_load_req();
        check_eq("to_clr_error", {31'd0, bus.error}, 32'd0);
        check_eq("to_clr_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        check_eq("to_clr_prog_ld", {31'd0, bus.prog_ld}, 32'd1);
        check_eq("to_clr_words", {16'd0, bus.words_loaded}, 32'd0);

        // 0001/FFFF image (sum wraps to 0000)
        img = '{16'h0001, 16'hFFFF};
        send_image(1'b0);
        check_run(2);
`ifdef PROG_LOADER_CHECKSUM_EN
        pulse_load_req();
        send_image(1'b1);
        check_eq("bad_sum_error", {31'd0, bus.error}, 32'd1);
        check_eq("bad_sum_done", {31'd0, bus.done}, 32'd0);
        check_eq("bad_sum_pc_reset", {31'd0, bus.cpu_pc_reset}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
